// File: rtl/spm_serial_ctrl_if.sv
// Operand, result and serial-array signals for spm_serial_ctrl.
// The master modport is the controller; the slave modport is the source, sink and array side.
interface spm_serial_ctrl_if #(parameter int WIDTH = 32);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_x;
  logic [WIDTH-1:0]     in_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic [WIDTH-1:0]     spm_x;
  logic                 spm_y;
  logic                 spm_rst;
  logic                 spm_p;

  modport master (
    input  in_valid, in_x, in_y, out_ready, spm_p,
    output in_ready, out_valid, out_p, spm_x, spm_y, spm_rst
  );

  modport slave (
    output in_valid, in_x, in_y, out_ready, spm_p,
    input  in_ready, out_valid, out_p, spm_x, spm_y, spm_rst
  );
endinterface

// File: rtl/spm_serial_ctrl.sv
// Sequencer for the spm serial-parallel multiplier: clear, stream y LSB-first, collect p.
// Accept-to-result latency 2+2*WIDTH+P_LAT cycles; the result is held in DONE until out_ready.
module spm_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int P_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  spm_serial_ctrl_if.master bus
);

  localparam int RUN_LEN = 2 * WIDTH + P_LAT;
  localparam int CW      = $clog2(RUN_LEN + 1);

  localparam logic [CW-1:0] LAST_C   = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] Y_LAST_C = CW'(2 * WIDTH - 1);
  localparam logic [CW-1:0] SAMPLE_C = CW'(P_LAT);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     ysr_q, ysr_d;
  logic [WIDTH-1:0]     spm_x_q, spm_x_d;
  logic                 spm_y_q, spm_y_d;
  logic                 spm_rst_q, spm_rst_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   out_p_q, out_p_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ysr_d     = ysr_q;
    spm_x_d   = spm_x_q;
    spm_y_d   = 1'b0;
    spm_rst_d = 1'b1;
    acc_d     = acc_q;
    out_p_d   = out_p_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          spm_x_d   = bus.in_x;
          ysr_d     = bus.in_y;
          spm_rst_d = 1'b0;
          cnt_d     = '0;
          state_d   = CLR;
        end
      end
      CLR: begin
        // Arithmetic shift: once y is exhausted its sign bit keeps feeding spm_y.
        spm_y_d = ysr_q[0];
        ysr_d   = {ysr_q[WIDTH-1], ysr_q[WIDTH-1:1]};
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q < Y_LAST_C) begin
          spm_y_d = ysr_q[0];
          ysr_d   = {ysr_q[WIDTH-1], ysr_q[WIDTH-1:1]};
        end
        if (cnt_q >= SAMPLE_C) begin
          acc_d = {bus.spm_p, acc_q[2*WIDTH-1:1]};
        end
        if (cnt_q == LAST_C) begin
          out_p_d = {bus.spm_p, acc_q[2*WIDTH-1:1]};
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ysr_q     <= '0;
      spm_x_q   <= '0;
      spm_y_q   <= 1'b0;
      spm_rst_q <= 1'b0;
      acc_q     <= '0;
      out_p_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ysr_q     <= ysr_d;
      spm_x_q   <= spm_x_d;
      spm_y_q   <= spm_y_d;
      spm_rst_q <= spm_rst_d;
      acc_q     <= acc_d;
      out_p_q   <= out_p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_p     = out_p_q;
  assign bus.spm_x     = spm_x_q;
  assign bus.spm_y     = spm_y_q;
  assign bus.spm_rst   = spm_rst_q;

endmodule

// File: tb/tb_spm_serial_ctrl.sv
// Bench for spm_serial_ctrl with a behavioural shift-add model of the spm array on the serial side.
module tb_spm_serial_ctrl;
  localparam int W       = 8;
  localparam int P       = 1;
  localparam int RUN_LEN = 2 * W + P;
  localparam int LAT     = 2 + RUN_LEN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spm_serial_ctrl_if #(.WIDTH(W)) bus();

  spm_serial_ctrl #(.WIDTH(W), .P_LAT(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Array model: running signed sum, emit LSB, halve; output delayed by P cycles.
  longint         acc;
  logic [P-1:0]   dl;
  assign bus.spm_p = dl[P-1];

  always @(posedge clk) begin : array_model
    longint s;
    if (!bus.spm_rst) begin
      acc <= 0;
      dl  <= '0;
    end else begin
      s = acc + (bus.spm_y ? longint'($signed(bus.spm_x)) : 64'sd0);
      acc   <= s >>> 1;
      dl[0] <= s[0];
      for (int i = 1; i < P; i++) dl[i] <= dl[i-1];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] exp_p;
  } vec_t;

  vec_t tbl[$];

  // Called at a negedge; leaves in_valid high, returns at the negedge before the accept edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("launch_timeout", 64'(n), 64'(0));
  endtask

  task automatic finish_op(input logic [W-1:0] x, input logic [W-1:0] y, input int stall,
                           input logic [2*W-1:0] exp_p);
    int cnt, rstlow, idx;
    logic clr_y;
    logic [RUN_LEN-1:0] seq, exp_seq;
    cnt = 0; rstlow = 0; idx = -1; clr_y = 1'b1; seq = '0;
    for (int c = 0; c < RUN_LEN; c++)
      exp_seq[c] = (c < W) ? y[c] : (c < 2*W) ? y[W-1] : 1'b0;
    while (!bus.out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (idx >= 0 && idx < RUN_LEN) begin
        seq[idx] = bus.spm_y;
        idx++;
      end
      if (!bus.spm_rst) begin
        rstlow++;
        clr_y = bus.spm_y;
        idx   = 0;
      end
    end
    check("latency", 64'(cnt), 64'(LAT));
    check("clr_cycles", 64'(rstlow), 64'(1));
    check("clr_spm_y", 64'(clr_y), 64'(0));
    check("spm_y_seq", 64'(seq), 64'(exp_seq));
    check("out_p", 64'(bus.out_p), 64'(exp_p));
    check("spm_x_held", 64'(bus.spm_x), 64'(x));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_p", 64'(bus.out_p), 64'(exp_p));
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      check("stall_out_valid", 64'(bus.out_valid), 64'(1));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_hs_out_valid", 64'(bus.out_valid), 64'(0));
    check("post_hs_in_ready", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0]   rx, ry;
    logic [2*W-1:0] rp;
    int n;
    bit seen;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_spm_rst", 64'(bus.spm_rst), 64'(0));
    check("rst_out_p", 64'(bus.out_p), 64'(0));
    check("rst_spm_x", 64'(bus.spm_x), 64'(0));
    check("rst_spm_y", 64'(bus.spm_y), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle_spm_rst", 64'(bus.spm_rst), 64'(1));
    check("idle_in_ready", 64'(bus.in_ready), 64'(1));

    // out_ready outside DONE must do nothing
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_out_ready_ignored", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    tbl.push_back('{8'd3,   8'd5,   16'h000F});
    tbl.push_back('{8'hFD,  8'd5,   16'hFFF1});
    tbl.push_back('{8'd127, 8'h80,  16'hC080});
    tbl.push_back('{8'h80,  8'h80,  16'h4000});
    tbl.push_back('{8'd127, 8'd127, 16'h3F01});
    tbl.push_back('{8'd1,   8'h80,  16'hFF80});
    tbl.push_back('{8'h00,  8'hA5,  16'h0000});
    tbl.push_back('{8'hFF,  8'd1,   16'hFFFF});

    // Back-to-back table ops: in_valid stays high across each handshake
    foreach (tbl[i]) begin
      launch(tbl[i].x, tbl[i].y);
      finish_op(tbl[i].x, tbl[i].y, 0, tbl[i].exp_p);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Stall in DONE for 10 cycles, then an immediate second product
    launch(8'd5, 8'd7);
    finish_op(8'd5, 8'd7, 10, 16'h0023);
    launch(8'd2, 8'd3);
    finish_op(8'd2, 8'd3, 0, 16'h0006);
    bus.in_valid = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rp = $signed(rx) * $signed(ry);
      launch(rx, ry);
      finish_op(rx, ry, int'($urandom_range(0, 3)), rp);
      bus.in_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Reset at RUN c=7
    launch(8'h55, 8'h33);
    n = 0;
    while (bus.spm_rst && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("find_clr", 64'(bus.spm_rst), 64'(0));
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_out_p", 64'(bus.out_p), 64'(0));
    check("midrst_spm_x", 64'(bus.spm_x), 64'(0));
    check("midrst_spm_y", 64'(bus.spm_y), 64'(0));
    check("midrst_spm_rst", 64'(bus.spm_rst), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'(0));
    launch(8'hFF, 8'hFF);
    finish_op(8'hFF, 8'hFF, 0, 16'h0001);
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spm_serial_ctrl.md
Name: spm_serial_ctrl

Overview:
- Sequencing stage wrapped around the spm carry-save multiplier array.
- Accepts a pair of parallel two's-complement operands over a valid/ready handshake.
- Presents x in parallel to the array, drives y serially LSB-first with sign extension, and deserialises the serial product output p into a 2*WIDTH-bit result.
- Issues the per-operation array clear, so stored carries and partial sums from a previous product never leak into the next one.

Parameters:
- WIDTH, 32, operand width; must match the spm array size; minimum 2.
- P_LAT, 1, cycles from a y bit being driven until the matching product bit appears on spm_p; range 1..4.

Ports:
- clk  input  1  rising-edge clock for this block and the spm array
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- in_x  input  WIDTH  multiplicand, two's complement
- in_y  input  WIDTH  multiplier, two's complement
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_p  output  2*WIDTH  signed product x*y
- spm_x  output  WIDTH  parallel operand to the array; registered and held for the whole operation
- spm_y  output  1  serial multiplier bit to the array; registered
- spm_rst  output  1  active-low clear to the array; registered
- spm_p  input  1  serial product bit from the array

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: in_ready=1, out_valid=0, out_p=0, spm_x=0, spm_y=0, spm_rst=0.
  - Internal state: state=IDLE, counter=0, y shift register=0.
  - Reset mid-operation aborts it; no partial result is ever presented.
- IDLE:
  - in_ready=1 and spm_rst=1.
  - On in_valid&in_ready: latch in_x to spm_x and in_y to the y shift register, then go to CLR.
- CLR (exactly 1 cycle):
  - spm_rst=0, spm_y=0, in_ready=0.
  - Counter c cleared to 0; next state RUN.
- RUN (2*WIDTH+P_LAT cycles, c=0..2*WIDTH+P_LAT-1):
  - spm_rst=1.
  - spm_y: y[c] for c<WIDTH; y[WIDTH-1] (sign extension) for WIDTH<=c<2*WIDTH; 0 for c>=2*WIDTH.
  - For c>=P_LAT, sample spm_p as product bit (c-P_LAT), shifted into the result register from the MSB end (right shift). After the final sample, bit 0 sits at out_p[0].
  - When c=2*WIDTH+P_LAT-1: load out_p and go to DONE.
- DONE:
  - out_valid=1; out_p is stable and spm_x is held.
  - On out_ready: out_valid drops next cycle and state returns to IDLE, so in_ready=1 that cycle.
  - If out_ready is low, DONE is held indefinitely with no change to out_p.
- Timing and arithmetic:
  - Accept-to-out_valid latency is exactly 1+2*WIDTH+P_LAT+1 cycles: accept edge, CLR, RUN, then register to DONE.
  - Minimum initiation interval is that latency plus 1 cycle.
  - Result is exact two's complement x*y in 2*WIDTH bits; no overflow is possible, including (-2^(W-1))*(-2^(W-1)).
- Boundary conditions:
  - in_valid asserted outside IDLE is ignored; the operands must be held by the source.
  - out_ready asserted outside DONE is ignored.
  - The counter width is clog2(2*WIDTH+P_LAT+1) and must not wrap within RUN.
  - No back-to-back accept in the same cycle as a result handoff.

Test Plan:
- WIDTH=8, P_LAT=1, reset then idle:
  - Stimulus: hold rst=0 for 3 cycles, then release.
  - Required response: in_ready=1, out_valid=0, spm_rst=0 during reset and 1 after, out_p=0.
- Unsigned-range product:
  - Stimulus: x=3, y=5.
  - Required response: out_p=16'h000F; out_valid rises exactly 19 cycles after the accept edge; spm_rst is low for exactly 1 cycle.
- Mixed sign:
  - Stimulus: x=-3 (8'hFD), y=5 → out_p=16'hFFF1.
  - Stimulus: x=127, y=-128 → out_p=16'hC080.
  - Required response: spm_y shows y[7] repeated for cycles 8..15 of RUN.
- Corner product:
  - Stimulus: x=-128, y=-128.
  - Required response: out_p=16'h4000.
- Back-pressure and sequencing:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, then release; keep in_valid high throughout.
  - Required response: out_p is stable during the stall; in_ready=0 until the cycle after the out_ready handshake.
  - Then issue a second product 2*3 → 16'h0006, proving the array was cleared between operations.
- Reset mid-RUN:
  - Stimulus: assert rst at c=7 of RUN.
  - Required response: out_valid never asserts and all outputs return to reset values immediately.
  - After release, x=-1, y=-1 → out_p=16'h0001.
